// File: rtl/threshold_trigger.sv
// Three-channel high-gain threshold coincidence trigger with holdoff and re-arm.
// Emits one registered pulse per qualifying event and counts triggers since reset.
module threshold_trigger #(
    parameter int HOLDOFF      = 2048,
    parameter int MULTIPLICITY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic [23:0] ADC0_IN,
    input  logic [23:0] ADC1_IN,
    input  logic [23:0] ADC2_IN,
    input  logic [11:0] THRESHOLD0,
    input  logic [11:0] THRESHOLD1,
    input  logic [11:0] THRESHOLD2,
    output logic        TRIG_OUT,
    output logic [2:0]  TRIG_PMT,
    output logic [31:0] TRIG_COUNT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_HOLDOFF,
        S_REARM
    } state_t;

    // A multiplicity of zero would fire on an empty event, so it is lifted to one.
    localparam logic [1:0]  MULT_EFF  = (MULTIPLICITY == 0) ? 2'd1 : 2'(MULTIPLICITY);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  above;
    logic [1:0]  nhit;
    logic        fire;
    logic [15:0] hold_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            above <= '0;
        end else begin
            above[0] <= (ADC0_IN[23:12] > THRESHOLD0);
            above[1] <= (ADC1_IN[23:12] > THRESHOLD1);
            above[2] <= (ADC2_IN[23:12] > THRESHOLD2);
        end
    end

    assign nhit = {1'b0, above[0]} + {1'b0, above[1]} + {1'b0, above[2]};
    assign fire = (nhit >= MULT_EFF) && ENABLE;

    // NOTE: next state gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (fire) state_nxt = S_TRIG;
            S_TRIG:    state_nxt = S_HOLDOFF;
            S_HOLDOFF: if (hold_cnt == 16'd0) state_nxt = S_REARM;
            S_REARM:   if (above == 3'b000) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            TRIG_OUT   <= 1'b0;
            TRIG_PMT   <= '0;
            TRIG_COUNT <= '0;
            BUSY       <= 1'b0;
        end else begin
            state    <= state_nxt;
            TRIG_OUT <= (state_nxt == S_TRIG);
            BUSY     <= (state_nxt != S_IDLE);

            // Pulse, mask and count all change on the edge that enters TRIG.
            if (state == S_IDLE && state_nxt == S_TRIG) begin
                TRIG_PMT <= above;
                if (TRIG_COUNT != 32'hFFFF_FFFF) begin
                    TRIG_COUNT <= TRIG_COUNT + 32'd1;
                end
            end

            if (state == S_TRIG) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == S_HOLDOFF && hold_cnt != 16'd0) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_threshold_trigger.sv
// Self-checking bench for threshold_trigger: directed scenarios plus randomized traffic,
// compared cycle by cycle against a timestamp-based model of the trigger rules.
module tb_threshold_trigger;

    localparam int HOLD = 16;
    localparam int MULT = 2;
    localparam int MULT_EFF = (MULT == 0) ? 1 : MULT;
    localparam logic [11:0] LOW   = 12'd200;
    localparam logic [11:0] SPIKE = 12'd4000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic [23:0] ADC0_IN, ADC1_IN, ADC2_IN;
    logic [11:0] THRESHOLD0, THRESHOLD1, THRESHOLD2;
    logic        TRIG_OUT;
    logic [2:0]  TRIG_PMT;
    logic [31:0] TRIG_COUNT;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    threshold_trigger #(.HOLDOFF(HOLD), .MULTIPLICITY(MULT)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
        .ADC0_IN(ADC0_IN), .ADC1_IN(ADC1_IN), .ADC2_IN(ADC2_IN),
        .THRESHOLD0(THRESHOLD0), .THRESHOLD1(THRESHOLD1), .THRESHOLD2(THRESHOLD2),
        .TRIG_OUT(TRIG_OUT), .TRIG_PMT(TRIG_PMT), .TRIG_COUNT(TRIG_COUNT), .BUSY(BUSY)
    );

    always #4 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        en;
        logic [11:0] hg0, hg1, hg2;
        logic [11:0] t0, t1, t2;
    } stim_t;

    stim_t       q[$];
    logic [11:0] cur_t0 = 12'd300, cur_t1 = 12'd300, cur_t2 = 12'd300;

    // Model: a trigger at cycle T makes the channel deaf until the first cycle
    // at or after T+HOLD+1 whose hit mask is empty; it is armed again from the next cycle.
    int          cyc = 0;
    bit          m_armed = 1'b1;
    int          m_rearm_from = 0;
    logic [2:0]  m_above = '0;
    logic        m_trig = 1'b0;
    logic [2:0]  m_pmt = '0;
    logic [31:0] m_count = '0;

    task automatic push(input logic [11:0] h0, input logic [11:0] h1, input logic [11:0] h2,
                        input int n, input logic en = 1'b1, input logic rst = 1'b0);
        stim_t s;
        s.rst = rst; s.en = en;
        s.hg0 = h0; s.hg1 = h1; s.hg2 = h2;
        s.t0 = cur_t0; s.t1 = cur_t1; s.t2 = cur_t2;
        repeat (n) q.push_back(s);
    endtask

    task automatic apply(input stim_t s);
        RST = s.rst;
        ENABLE = s.en;
        ADC0_IN = {s.hg0, 12'($urandom)};
        ADC1_IN = {s.hg1, 12'($urandom)};
        ADC2_IN = {s.hg2, 12'($urandom)};
        THRESHOLD0 = s.t0; THRESHOLD1 = s.t1; THRESHOLD2 = s.t2;
    endtask

    task automatic step();
        logic [2:0] a_new;
        bit fire;
        a_new = {ADC2_IN[23:12] > THRESHOLD2, ADC1_IN[23:12] > THRESHOLD1, ADC0_IN[23:12] > THRESHOLD0};
        @(posedge CLK);
        cyc++;
        if (RST) begin
            m_armed = 1'b1; m_above = '0; m_trig = 1'b0; m_pmt = '0; m_count = '0;
        end else begin
            fire = m_armed && ENABLE && ($countones(m_above) >= MULT_EFF);
            m_trig = fire;
            if (fire) begin
                m_armed = 1'b0;
                m_rearm_from = cyc + HOLD + 1;
                m_pmt = m_above;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            end else if (!m_armed && (cyc - 1 >= m_rearm_from) && m_above == 3'b000) begin
                m_armed = 1'b1;
            end
            m_above = a_new;
        end
        #1;
    endtask

    task automatic test_reset();
        int trig_at[$];
        q.delete();
        cur_t0 = 12'd300; cur_t1 = 12'd300; cur_t2 = 12'd300;
        push(LOW, LOW, LOW, 3, 1'b1, 1'b1);
        push(LOW, LOW, LOW, 10000);
        foreach (q[i]) begin
            apply(q[i]);
            step();
            checks++;
            if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== {m_trig, !m_armed, m_pmt, m_count}) begin
                errors++;
                $display("FAIL reset_model i=%0d got trig=%b busy=%b pmt=%b cnt=%0d exp trig=%b busy=%b pmt=%b cnt=%0d",
                         i, TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT, m_trig, !m_armed, m_pmt, m_count);
            end
            if (i == 2) begin
                checks++;
                if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== 37'd0) begin
                    errors++;
                    $display("FAIL reset_outputs got trig=%b busy=%b pmt=%b cnt=%0d exp all zero",
                             TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT);
                end
            end
            if (TRIG_OUT === 1'b1) trig_at.push_back(i);
        end
        checks++;
        if (trig_at.size() != 0) begin
            errors++;
            $display("FAIL reset_quiet got %0d pulses exp 0", trig_at.size());
        end
    endtask

    task automatic test_ramp();
        int trig_at[$];
        q.delete();
        for (int i = 0; i < 260; i++) push(12'(200 + i), 12'(200 + i), 12'(200 + i), 1);
        push(LOW, LOW, LOW, 30);
        foreach (q[i]) begin
            apply(q[i]);
            step();
            checks++;
            if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== {m_trig, !m_armed, m_pmt, m_count}) begin
                errors++;
                $display("FAIL ramp_model i=%0d got trig=%b busy=%b pmt=%b cnt=%0d exp trig=%b busy=%b pmt=%b cnt=%0d",
                         i, TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT, m_trig, !m_armed, m_pmt, m_count);
            end
            if (TRIG_OUT === 1'b1) trig_at.push_back(i);
        end
        // HG 301 is sampled at edge 101, so the pulse follows edge 102.
        checks++;
        if (trig_at.size() != 1 || trig_at[0] != 102) begin
            errors++;
            $display("FAIL ramp_pulse got count=%0d first=%0d exp count=1 first=102",
                     trig_at.size(), (trig_at.size() > 0) ? trig_at[0] : -1);
        end
        checks++;
        if (TRIG_PMT !== 3'b111 || TRIG_COUNT !== 32'd1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL ramp_final got pmt=%b cnt=%0d busy=%b exp pmt=111 cnt=1 busy=0",
                     TRIG_PMT, TRIG_COUNT, BUSY);
        end
    endtask

    task automatic test_multiplicity();
        int trig_at[$];
        q.delete();
        push(12'd400, LOW, LOW, 30);
        push(12'd400, LOW, 12'd400, 1);
        push(LOW, LOW, LOW, 40);
        foreach (q[i]) begin
            apply(q[i]);
            step();
            checks++;
            if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== {m_trig, !m_armed, m_pmt, m_count}) begin
                errors++;
                $display("FAIL mult_model i=%0d got trig=%b busy=%b pmt=%b cnt=%0d exp trig=%b busy=%b pmt=%b cnt=%0d",
                         i, TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT, m_trig, !m_armed, m_pmt, m_count);
            end
            if (TRIG_OUT === 1'b1) trig_at.push_back(i);
        end
        checks++;
        if (trig_at.size() != 1 || trig_at[0] != 31 || TRIG_PMT !== 3'b101) begin
            errors++;
            $display("FAIL mult_gate got pulses=%0d first=%0d pmt=%b exp pulses=1 first=31 pmt=101",
                     trig_at.size(), (trig_at.size() > 0) ? trig_at[0] : -1, TRIG_PMT);
        end
    endtask

    task automatic test_equality();
        int trig_at[$];
        q.delete();
        push(12'd300, 12'd300, 12'd300, 20);
        push(12'd301, 12'd301, 12'd301, 1);
        push(LOW, LOW, LOW, 40);
        foreach (q[i]) begin
            apply(q[i]);
            step();
            checks++;
            if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== {m_trig, !m_armed, m_pmt, m_count}) begin
                errors++;
                $display("FAIL equal_model i=%0d got trig=%b busy=%b pmt=%b cnt=%0d exp trig=%b busy=%b pmt=%b cnt=%0d",
                         i, TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT, m_trig, !m_armed, m_pmt, m_count);
            end
            if (TRIG_OUT === 1'b1) trig_at.push_back(i);
        end
        checks++;
        if (trig_at.size() != 1 || trig_at[0] != 21) begin
            errors++;
            $display("FAIL equal_boundary got pulses=%0d first=%0d exp pulses=1 first=21",
                     trig_at.size(), (trig_at.size() > 0) ? trig_at[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        int trig_at[$];
        int exp_at[4] = '{1, 52, 71, 112};
        q.delete();
        push(SPIKE, SPIKE, SPIKE, 1); push(LOW, LOW, LOW, 9);
        push(SPIKE, SPIKE, SPIKE, 1); push(LOW, LOW, LOW, 40);
        push(SPIKE, SPIKE, SPIKE, 1); push(LOW, LOW, LOW, 18);
        push(SPIKE, SPIKE, SPIKE, 1); push(LOW, LOW, LOW, 40);
        push(SPIKE, SPIKE, SPIKE, 1); push(LOW, LOW, LOW, 17);
        push(SPIKE, SPIKE, SPIKE, 1); push(LOW, LOW, LOW, 40);
        foreach (q[i]) begin
            apply(q[i]);
            step();
            checks++;
            if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== {m_trig, !m_armed, m_pmt, m_count}) begin
                errors++;
                $display("FAIL b2b_model i=%0d got trig=%b busy=%b pmt=%b cnt=%0d exp trig=%b busy=%b pmt=%b cnt=%0d",
                         i, TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT, m_trig, !m_armed, m_pmt, m_count);
            end
            if (TRIG_OUT === 1'b1) trig_at.push_back(i);
        end
        checks++;
        if (trig_at.size() != 4) begin
            errors++;
            $display("FAIL b2b_pulse_count got %0d exp 4", trig_at.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (trig_at[k] != exp_at[k]) begin
                    errors++;
                    $display("FAIL b2b_pulse_at k=%0d got %0d exp %0d", k, trig_at[k], exp_at[k]);
                end
            end
            checks++;
            if (trig_at[2] - trig_at[1] != HOLD + 3) begin
                errors++;
                $display("FAIL b2b_spacing got %0d exp %0d", trig_at[2] - trig_at[1], HOLD + 3);
            end
        end
    endtask

    task automatic test_control();
        int trig_at[$];
        int exp_at[3] = '{32, 77, 90};
        bit busy_seen = 1'b0;
        q.delete();
        push(SPIKE, SPIKE, SPIKE, 1, 1'b0); push(LOW, LOW, LOW, 30, 1'b0);
        push(SPIKE, SPIKE, SPIKE, 1);       push(LOW, LOW, LOW, 4);
        push(LOW, LOW, LOW, 40, 1'b0);
        push(SPIKE, SPIKE, SPIKE, 1);       push(LOW, LOW, LOW, 6);
        push(LOW, LOW, LOW, 1, 1'b1, 1'b1); push(LOW, LOW, LOW, 5);
        push(SPIKE, SPIKE, SPIKE, 1);       push(LOW, LOW, LOW, 40);
        foreach (q[i]) begin
            apply(q[i]);
            step();
            checks++;
            if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== {m_trig, !m_armed, m_pmt, m_count}) begin
                errors++;
                $display("FAIL ctrl_model i=%0d got trig=%b busy=%b pmt=%b cnt=%0d exp trig=%b busy=%b pmt=%b cnt=%0d",
                         i, TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT, m_trig, !m_armed, m_pmt, m_count);
            end
            if (TRIG_OUT === 1'b1) trig_at.push_back(i);
            if (i <= 30 && BUSY !== 1'b0) busy_seen = 1'b1;
            if (i == 75) begin
                checks++;
                if (BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL ctrl_enable_drop got busy=%b exp busy=0", BUSY);
                end
            end
            if (i == 83) begin
                checks++;
                if (BUSY !== 1'b0 || TRIG_COUNT !== 32'd0 || TRIG_OUT !== 1'b0) begin
                    errors++;
                    $display("FAIL ctrl_mid_reset got busy=%b cnt=%0d trig=%b exp busy=0 cnt=0 trig=0",
                             BUSY, TRIG_COUNT, TRIG_OUT);
                end
            end
        end
        checks++;
        if (busy_seen) begin
            errors++;
            $display("FAIL ctrl_disabled_busy got busy=1 exp busy=0");
        end
        checks++;
        if (trig_at.size() != 3 || trig_at[0] != exp_at[0] || trig_at[1] != exp_at[1] ||
            trig_at[2] != exp_at[2] || TRIG_COUNT !== 32'd1) begin
            errors++;
            $display("FAIL ctrl_pulses got pulses=%0d cnt=%0d exp pulses at 32,77,90 cnt=1",
                     trig_at.size(), TRIG_COUNT);
        end
    endtask

    task automatic test_random();
        logic [11:0] hg[3];
        logic [11:0] thr[3];
        logic        en = 1'b1;
        logic        rst;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (c == 0 || $urandom_range(0, 199) == 0) begin
                cur_t0 = 12'($urandom_range(100, 3900));
                cur_t1 = 12'($urandom_range(100, 3900));
                cur_t2 = 12'($urandom_range(100, 3900));
            end
            thr[0] = cur_t0; thr[1] = cur_t1; thr[2] = cur_t2;
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(0, 9) < 2) hg[n] = thr[n] + 12'($urandom_range(1, 50));
                else hg[n] = thr[n] - 12'($urandom_range(0, 50));
            end
            if ($urandom_range(0, 49) == 0) en = ~en;
            rst = ($urandom_range(0, 499) == 0);
            push(hg[0], hg[1], hg[2], 1, en, rst);
        end
        foreach (q[i]) begin
            apply(q[i]);
            step();
            checks++;
            if ({TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT} !== {m_trig, !m_armed, m_pmt, m_count}) begin
                errors++;
                $display("FAIL rand_model i=%0d got trig=%b busy=%b pmt=%b cnt=%0d exp trig=%b busy=%b pmt=%b cnt=%0d",
                         i, TRIG_OUT, BUSY, TRIG_PMT, TRIG_COUNT, m_trig, !m_armed, m_pmt, m_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_multiplicity();
        test_equality();
        test_back_to_back();
        test_control();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
